serial_mag_cmp: RTL
===================

# serial_mag_cmp

Multi-word magnitude comparator that decides A>B, A=B or A<B for operands wider than one comparator slice. Operands arrive as SLICE_W-bit slice pairs, least-significant slice first, over a valid/ready stream. Each slice is resolved with the same greater/equal/less cascade rule as our 4-bit combinational comparator, and the result is carried across beats in registers. It sits between an operand streamer and a result consumer that applies back-pressure through a handshake.

## Interface
- SLICE_W, 4: width of each operand slice, ≥1
- NUM_SLICES, 8: maximum slices per comparison, ≥1
- clk input 1: single clock, rising edge
- rst_n input 1: asynchronous, active-low reset
- in_valid input 1: slice beat valid
- in_ready output 1: block accepts a beat this cycle
- in_a input SLICE_W: slice of operand A
- in_b input SLICE_W: slice of operand B
- in_last input 1: this beat is the most-significant slice
- cas_gt, cas_eq, cas_lt input 1 each: cascade seed, sampled only on the first beat of a comparison
- res_valid output 1: result available
- res_ready input 1: consumer takes the result
- res_gt, res_eq, res_lt output 1 each: one-hot comparison result
- res_err output 1: cascade seed not one-hot, or slice overrun
- res_slices output $clog2(NUM_SLICES+1): number of beats consumed

## Operation
- The FSM has three states: IDLE, ACC and DONE.
- IDLE
  - in_ready=1.
  - On in_valid, the block latches the cascade seed into state {gt,eq,lt}.
  - If the seed is not exactly one-hot, the block sets the error flag and forces the state to eq=1.
  - The block then applies the slice rule, sets count=1, and goes to DONE if in_last, otherwise to ACC.
- Slice rule, unsigned compare of in_a and in_b:
  - in_a>in_b sets the state to gt.
  - in_a<in_b sets the state to lt.
  - Equal slices keep the previous state.
- ACC
  - in_ready=1.
  - Each accepted beat applies the slice rule and increments count.
  - The block goes to DONE on in_last.
  - If count reaches NUM_SLICES on a beat without in_last, the block sets the error flag, goes to DONE, and ignores later beats until the next IDLE.
- DONE
  - in_ready=0 and res_valid=1.
  - All res_* outputs hold stable until res_ready.
  - On res_ready the block clears count and the error flag and goes to IDLE.
- res_* are registered outputs that drive the current state, count and error flag. They are meaningful only while res_valid=1.
- Reset value of every output: in_ready=1, res_valid=0, res_gt=0, res_eq=1, res_lt=0, res_err=0, res_slices=0. The FSM resets to IDLE.
- Reset mid-comparison discards the partial result immediately.

## Timing
- A beat is accepted on any rising edge where in_valid && in_ready.
- res_valid rises on the cycle after the in_last beat is accepted. Latency is 1 cycle.
- The result is taken on a rising edge where res_valid && res_ready. in_ready returns the following cycle, so back-to-back comparisons have one bubble cycle.
- If res_ready is already high when DONE is entered, DONE lasts exactly one cycle.
- Throughput is one slice per cycle while in ACC.
- in_a, in_b and in_last are ignored while in_ready=0. The cascade inputs are ignored on every beat except the first.

## Configuration
- SMC_SIGNED_EN defined
  - The slice carrying in_last is compared as SLICE_W-bit two's complement.
  - All other slices stay unsigned, so the full operands compare as signed integers.
- SMC_SIGNED_EN undefined
  - Every slice compares unsigned.
  - No sign logic is synthesized.

## Test plan
- Reset with rst_n=0, then release -> in_ready=1, res_valid=0, res_eq=1, res_slices=0.
- Seed eq, then beats (a,b)=(3,5), (9,9), (A,2) with the last beat flagged -> res_gt=1, res_slices=3, res_err=0, res_valid one cycle after the third beat.
- Seed lt, then two beats (7,7), (7,7) with last flagged -> res_lt=1, since the seed propagates through equal slices.
- Seed gt=1 and lt=1, one beat (4,4) with last -> res_eq=1, res_err=1.
- NUM_SLICES=8, 8 beats without in_last -> DONE after beat 8 with res_err=1 and res_slices=8; the 9th beat is not accepted while in DONE.
- Back-pressure: hold res_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout. With SMC_SIGNED_EN, a single beat (0xF,0x1) with last -> res_lt=1; without the macro -> res_gt=1.

Source files
------------

// File: rtl/serial_mag_cmp.sv
// Multi-word magnitude comparator. Operands stream in as slice pairs, least-significant slice first.
// Defining SMC_SIGNED_EN makes the in_last slice compare as two's complement, so the full operands compare as signed values.
module serial_mag_cmp #(
    parameter int SLICE_W    = 4,
    parameter int NUM_SLICES = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [SLICE_W-1:0]                in_a,
    input  logic [SLICE_W-1:0]                in_b,
    input  logic                              in_last,
    input  logic                              cas_gt,
    input  logic                              cas_eq,
    input  logic                              cas_lt,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic                              res_gt,
    output logic                              res_eq,
    output logic                              res_lt,
    output logic                              res_err,
    output logic [$clog2(NUM_SLICES+1)-1:0]   res_slices
);

    localparam int CW = $clog2(NUM_SLICES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(NUM_SLICES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic            gt_r;
    logic            eq_r;
    logic            lt_r;
    logic [CW-1:0]   cnt_r;
    logic            err_r;
    logic            in_ready_r;
    logic            res_valid_r;

    logic            seed_ok_s;
    logic [2:0]      base_s;
    logic [1:0]      cmp_s;
    logic [2:0]      next_res_s;
    logic [CW-1:0]   cnt_inc_s;
    logic            overrun_s;

    function automatic logic is_one_hot3(input logic [2:0] v);
        logic r;
        case (v)
            3'b100:  r = 1'b1;
            3'b010:  r = 1'b1;
            3'b001:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

`ifdef SMC_SIGNED_EN
    // Returns {a_gt_b, a_lt_b}; the most-significant slice carries the sign.
    function automatic logic [1:0] slice_cmp(input logic [SLICE_W-1:0] a,
                                             input logic [SLICE_W-1:0] b,
                                             input logic               is_msb);
        logic [1:0] r;
        if (is_msb) begin
            r = {($signed(a) > $signed(b)), ($signed(a) < $signed(b))};
        end else begin
            r = {(a > b), (a < b)};
        end
        return r;
    endfunction
`else
    // Returns {a_gt_b, a_lt_b}.
    function automatic logic [1:0] slice_cmp(input logic [SLICE_W-1:0] a,
                                             input logic [SLICE_W-1:0] b);
        return {(a > b), (a < b)};
    endfunction
`endif

    // Resolve the incoming slice against the running (or freshly seeded) cascade state.
    always_comb begin
        seed_ok_s = is_one_hot3({cas_gt, cas_eq, cas_lt});
        base_s    = {gt_r, eq_r, lt_r};
        if (state_r == IDLE) begin
            base_s = seed_ok_s ? {cas_gt, cas_eq, cas_lt} : 3'b010;
        end else begin
            base_s = {gt_r, eq_r, lt_r};
        end
`ifdef SMC_SIGNED_EN
        cmp_s = slice_cmp(in_a, in_b, in_last);
`else
        cmp_s = slice_cmp(in_a, in_b);
`endif
        if (cmp_s[1]) begin
            next_res_s = 3'b100;
        end else if (cmp_s[0]) begin
            next_res_s = 3'b001;
        end else begin
            next_res_s = base_s;
        end
        // cnt_r is zero in IDLE, so the same increment yields the first-beat count of one.
        cnt_inc_s = cnt_r + CNT_ONE;
        overrun_s = !in_last && (cnt_inc_s == CNT_MAX);
    end

    // Comparison FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gt_r        <= 1'b0;
            eq_r        <= 1'b1;
            lt_r        <= 1'b0;
            cnt_r       <= '0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            res_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        {gt_r, eq_r, lt_r} <= next_res_s;
                        cnt_r              <= cnt_inc_s;
                        err_r              <= !seed_ok_s || overrun_s;
                        if (in_last || overrun_s) begin
                            state_r     <= DONE;
                            in_ready_r  <= 1'b0;
                            res_valid_r <= 1'b1;
                        end else begin
                            state_r <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        {gt_r, eq_r, lt_r} <= next_res_s;
                        cnt_r              <= cnt_inc_s;
                        err_r              <= err_r || overrun_s;
                        if (in_last || overrun_s) begin
                            state_r     <= DONE;
                            in_ready_r  <= 1'b0;
                            res_valid_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_r     <= IDLE;
                        cnt_r       <= '0;
                        err_r       <= 1'b0;
                        in_ready_r  <= 1'b1;
                        res_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    gt_r        <= 1'b0;
                    eq_r        <= 1'b1;
                    lt_r        <= 1'b0;
                    cnt_r       <= '0;
                    err_r       <= 1'b0;
                    in_ready_r  <= 1'b1;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign res_valid  = res_valid_r;
    assign res_gt     = gt_r;
    assign res_eq     = eq_r;
    assign res_lt     = lt_r;
    assign res_err    = err_r;
    assign res_slices = cnt_r;

endmodule
